// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: one shared sprite ROM serves NUM_SPR sprites (index 0 = player).
// On line_start it scans every sprite against next_line and streams SPR_W pixels of
// each hit sprite's row from the ROM into that sprite's line buffer.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   line_start        one-cycle pulse, begin fetch for next_line
//   next_line         scanline to prepare (sampled on line_start)
//   spr_y, spr_base   packed per-sprite top row (10b) and frame base address
//   rom_en, rom_addr  ROM read request
//   rom_data          ROM pixel, valid ROM_LAT cycles after rom_en
//   buf_we/sel/addr   line-buffer write (sprite index, pixel column)
//   buf_wdata         rom_data while buf_we is high, otherwise 0
//   spr_hit           hit mask of the last completed line
//   busy, done        fetch in progress / line buffers complete pulse
//   overrun           pulse when line_start arrives while busy
//   overrun_cnt       saturating overrun counter, only with OVERRUN_CNT_EN defined
module sprite_line_fetcher #(
  parameter int unsigned NUM_SPR = 6,
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_H   = 16,
  parameter int unsigned SHEET_W = 48,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_start,
  input  logic [9:0]                next_line,
  input  logic [10*NUM_SPR-1:0]     spr_y,
  input  logic [ADDR_W*NUM_SPR-1:0] spr_base,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [7:0]                rom_data,
  output logic                      buf_we,
  output logic [2:0]                buf_sel,
  output logic [3:0]                buf_addr,
  output logic [7:0]                buf_wdata,
  output logic [NUM_SPR-1:0]        spr_hit,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [7:0]                overrun_cnt
`endif
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned COL_W = 4;
  localparam int unsigned LAT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH, S_DRAIN} state_t;

  state_t                state_q, state_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [COL_W-1:0]      col_q, col_n;
  logic [9:0]            row_q, row_n;
  logic [9:0]            line_q, line_n;
  logic [NUM_SPR-1:0]    mask_q, mask_n;
  logic [LAT_W-1:0]      drain_q, drain_n;
  logic                  rom_en_n, busy_n, done_n, overrun_n, buf_we_n;
  logic [ADDR_W-1:0]     rom_addr_n;
  logic [NUM_SPR-1:0]    hit_n;
  logic [IDX_W-1:0]      buf_sel_n;
  logic [COL_W-1:0]      buf_addr_n;

  // Write pipeline: stage 0 lines up with the registered ROM request.
  logic                  pv_q [ROM_LAT];
  logic                  pv_n [ROM_LAT];
  logic [IDX_W-1:0]      ps_q [ROM_LAT];
  logic [IDX_W-1:0]      ps_n [ROM_LAT];
  logic [COL_W-1:0]      pc_q [ROM_LAT];
  logic [COL_W-1:0]      pc_n [ROM_LAT];

  // Current sprite's row within itself; mod-1024 subtraction handles wrap at the top.
  logic [9:0]            y_cur_c, row_cur_c;
  logic [ADDR_W-1:0]     base_cur_c;
  logic                  last_c;

  assign y_cur_c    = spr_y[10*32'(idx_q) +: 10];
  assign base_cur_c = spr_base[ADDR_W*32'(idx_q) +: ADDR_W];
  assign row_cur_c  = line_q - y_cur_c;
  assign last_c     = (idx_q == IDX_W'(NUM_SPR - 1));

  // Pixel data passes straight through so it meets the write in the same cycle.
  assign buf_wdata  = buf_we ? rom_data : 8'h00;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [9:0]        row,
                                                 input logic [COL_W-1:0]  col);
    logic [31:0] sum;
    sum = 32'(base) + 32'(row) * 32'(SHEET_W) + 32'(col);
    return ADDR_W'(sum);
  endfunction

  // Next-state and registered-output values.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    col_n      = col_q;
    row_n      = row_q;
    line_n     = line_q;
    mask_n     = mask_q;
    drain_n    = drain_q;
    rom_en_n   = 1'b0;
    rom_addr_n = '0;
    busy_n     = busy;
    done_n     = 1'b0;
    overrun_n  = 1'b0;
    hit_n      = spr_hit;

    case (state_q)
      S_IDLE: begin
        if (line_start) begin
          line_n  = next_line;
          idx_n   = '0;
          mask_n  = '0;
          busy_n  = 1'b1;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (row_cur_c < 10'(SPR_H)) begin
          mask_n     = mask_q | (NUM_SPR'(1) << idx_q);
          row_n      = row_cur_c;
          col_n      = '0;
          rom_en_n   = 1'b1;
          rom_addr_n = pix_addr(base_cur_c, row_cur_c, '0);
          state_n    = S_FETCH;
        end else if (last_c) begin
          drain_n = '0;
          state_n = S_DRAIN;
        end else begin
          idx_n = idx_q + IDX_W'(1);
        end
      end
      S_FETCH: begin
        // col_q is the column currently on the ROM bus.
        if (col_q == COL_W'(SPR_W - 1)) begin
          if (last_c) begin
            drain_n = '0;
            state_n = S_DRAIN;
          end else begin
            idx_n   = idx_q + IDX_W'(1);
            state_n = S_SCAN;
          end
        end else begin
          col_n      = col_q + COL_W'(1);
          rom_en_n   = 1'b1;
          rom_addr_n = pix_addr(base_cur_c, row_q, col_q + COL_W'(1));
        end
      end
      S_DRAIN: begin
        if (drain_q == LAT_W'(ROM_LAT - 1)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          hit_n   = mask_q;
          state_n = S_IDLE;
        end else begin
          drain_n = drain_q + LAT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    pv_n[0] = rom_en_n;
    ps_n[0] = idx_q;
    pc_n[0] = col_n;
    for (int k = 1; k < int'(ROM_LAT); k++) begin
      pv_n[k] = pv_q[k-1];
      ps_n[k] = ps_q[k-1];
      pc_n[k] = pc_q[k-1];
    end
    buf_we_n   = pv_q[ROM_LAT-1];
    buf_sel_n  = ps_q[ROM_LAT-1];
    buf_addr_n = pc_q[ROM_LAT-1];

    // Overrun: abandon the current line, drop in-flight writes, restart the scan.
    if (line_start && busy) begin
      overrun_n  = 1'b1;
      line_n     = next_line;
      idx_n      = '0;
      mask_n     = '0;
      busy_n     = 1'b1;
      done_n     = 1'b0;
      hit_n      = spr_hit;
      rom_en_n   = 1'b0;
      rom_addr_n = '0;
      state_n    = S_SCAN;
      for (int k = 0; k < int'(ROM_LAT); k++) pv_n[k] = 1'b0;
      buf_we_n   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      line_q   <= '0;
      mask_q   <= '0;
      drain_q  <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      buf_we   <= 1'b0;
      buf_sel  <= '0;
      buf_addr <= '0;
      spr_hit  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      for (int k = 0; k < int'(ROM_LAT); k++) begin
        pv_q[k] <= 1'b0;
        ps_q[k] <= '0;
        pc_q[k] <= '0;
      end
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      col_q    <= col_n;
      row_q    <= row_n;
      line_q   <= line_n;
      mask_q   <= mask_n;
      drain_q  <= drain_n;
      rom_en   <= rom_en_n;
      rom_addr <= rom_addr_n;
      buf_we   <= buf_we_n;
      buf_sel  <= buf_sel_n;
      buf_addr <= buf_addr_n;
      spr_hit  <= hit_n;
      busy     <= busy_n;
      done     <= done_n;
      overrun  <= overrun_n;
      for (int k = 0; k < int'(ROM_LAT); k++) begin
        pv_q[k] <= pv_n[k];
        ps_q[k] <= ps_n[k];
        pc_q[k] <= pc_n[k];
      end
    end
  end

`ifdef OVERRUN_CNT_EN
  // Saturating count of overrun pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   overrun_cnt <= 8'h00;
    else if (overrun && overrun_cnt != 8'hFF)  overrun_cnt <= overrun_cnt + 8'h01;
  end
`endif

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed self-checking bench for sprite_line_fetcher (default parameters, ROM_LAT=1).
module tb_sprite_line_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [9:0]  next_line;
  logic [59:0] spr_y;
  logic [71:0] spr_base;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        buf_we;
  logic [2:0]  buf_sel;
  logic [3:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic [5:0]  spr_hit;
  logic        busy, done, overrun;
`ifdef OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  sprite_line_fetcher dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_line(next_line),
    .spr_y(spr_y), .spr_base(spr_base), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .spr_hit(spr_hit), .busy(busy), .done(done),
    .overrun(overrun)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM with one cycle of read latency; contents are a hash of the address.
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    return 8'(a) ^ 8'(a >> 4) ^ 8'h5A;
  endfunction

  always @(posedge clk) rom_data <= rom_en ? rom_f(rom_addr) : 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected ROM reads and buffer writes for one line.
  logic [11:0] exp_addr_q[$];
  logic [14:0] exp_wr_q[$];

  task automatic build_model(input logic [59:0] y, input logic [71:0] b, input logic [9:0] ln);
    logic [9:0]  row;
    logic [11:0] a;
    exp_addr_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 6; i++) begin
      row = ln - y[10*i +: 10];
      if (row < 10'd16) begin
        for (int c = 0; c < 16; c++) begin
          a = 12'(32'(b[12*i +: 12]) + 32'(row) * 32'd48 + 32'(c));
          exp_addr_q.push_back(a);
          exp_wr_q.push_back({3'(i), 4'(c), rom_f(a)});
        end
      end
    end
  endtask

  int          r_done, r_reads, r_over;
  logic [5:0]  r_hit;
  logic [31:0] r_first;

  // Pulse line_start (cycle 0) and watch the line until done or the budget runs out.
  task automatic run_line(input string tag, input bit nowait, input int limit);
    logic [11:0] ea;
    logic [14:0] ew;
    r_done = -1; r_reads = 0; r_over = 0; r_hit = '0; r_first = 32'hFFFF_FFFF;
    if (!nowait) @(negedge clk);
    line_start = 1'b1;
    for (int cyc = 1; cyc <= limit && r_done < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) line_start = 1'b0;
      if (rom_en) begin
        if (r_reads == 0) r_first = 32'(rom_addr);
        r_reads++;
        ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 12'hFFF;
        if (rom_addr !== ea) begin
          checks++; errors++;
          $display("FAIL %s rom_addr: got %0h, expected %0h", tag, rom_addr, ea);
        end
      end
      if (buf_we) begin
        ew = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 15'h7FFF;
        chk({tag, " write{sel,col,data}"}, 32'({buf_sel, buf_addr, buf_wdata}), 32'(ew));
      end
      if (overrun) r_over++;
      if (done) begin
        r_done = cyc;
        r_hit  = spr_hit;
        chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, " writes_left"}, 32'(exp_wr_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [59:0] y;
    logic [71:0] base;
    logic [9:0]  line;
    logic [5:0]  hit;
    int          done_cyc;
    int          reads;
    logic [31:0] first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{y: {10'd600, 10'd600, 10'd600, 10'd600, 10'd600, 10'd100}, base: 72'h0,
                line: 10'd105, hit: 6'b000001, done_cyc: 24, reads: 16, first: 32'h0F0};
    vecs[1] = '{y: {6{10'd600}}, base: 72'h0,
                line: 10'd10, hit: 6'b000000, done_cyc: 8, reads: 0, first: 32'hFFFF_FFFF};
    vecs[2] = '{y: {10'd600, 10'd600, 10'd1020, 10'd600, 10'd600, 10'd600},
                base: {12'h0, 12'h0, 12'h100, 12'h0, 12'h0, 12'h0},
                line: 10'd2, hit: 6'b001000, done_cyc: 24, reads: 16, first: 32'h220};
    vecs[3] = '{y: {6{10'd40}},
                base: {12'hA00, 12'h800, 12'h600, 12'h400, 12'h200, 12'h000},
                line: 10'd50, hit: 6'b111111, done_cyc: 104, reads: 96, first: 32'h1E0};
    // Row 16 just misses, row 15 just hits, last sprite hits, address wraps past 0xFFF.
    vecs[4] = '{y: {10'd200, 10'd600, 10'd600, 10'd600, 10'd185, 10'd184},
                base: {12'h010, 12'h0, 12'h0, 12'h0, 12'hFF0, 12'h0},
                line: 10'd200, hit: 6'b100010, done_cyc: 40, reads: 32, first: 32'h2C0};

    rst = 1'b1; line_start = 1'b0; next_line = '0; spr_y = '0; spr_base = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({rom_en, rom_addr, buf_we, buf_sel, buf_addr, buf_wdata,
                              spr_hit, busy, done, overrun}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      spr_y = vecs[v].y; spr_base = vecs[v].base; next_line = vecs[v].line;
      build_model(vecs[v].y, vecs[v].base, vecs[v].line);
      run_line($sformatf("v%0d", v), 1'b0, 200);
      chk($sformatf("v%0d done_cycle", v), 32'(r_done), 32'(vecs[v].done_cyc));
      chk($sformatf("v%0d spr_hit", v), 32'(r_hit), 32'(vecs[v].hit));
      chk($sformatf("v%0d reads", v), 32'(r_reads), 32'(vecs[v].reads));
      chk($sformatf("v%0d first_addr", v), r_first, vecs[v].first);
      chk($sformatf("v%0d overrun", v), 32'(r_over), 32'd0);
    end

    // line_start in the done cycle starts a new line, not an overrun.
    spr_y = vecs[0].y; spr_base = vecs[0].base; next_line = vecs[0].line;
    build_model(vecs[0].y, vecs[0].base, vecs[0].line);
    run_line("chain_a", 1'b0, 200);
    build_model(vecs[0].y, vecs[0].base, vecs[0].line);
    run_line("chain_b", 1'b1, 200);
    chk("chain done_cycle", 32'(r_done), 32'd24);
    chk("chain overrun", 32'(r_over), 32'd0);

    // Overrun: all-hit line 50, second line_start (line 45) at cycle 30.
    spr_y = vecs[3].y; spr_base = vecs[3].base; next_line = 10'd50;
    @(negedge clk);
    line_start = 1'b1;
    begin
      int early_done;
      early_done = 0;
      for (int cyc = 1; cyc < 30; cyc++) begin
        @(negedge clk);
        if (cyc == 1) begin
          line_start = 1'b0;
          next_line  = 10'd45;
        end
        if (done) early_done++;
      end
      chk("ovr no early done", 32'(early_done), 32'd0);
    end
    build_model(vecs[3].y, vecs[3].base, 10'd45);
    run_line("ovr", 1'b0, 200);
    chk("ovr done_cycle", 32'(r_done), 32'd104);
    chk("ovr pulses", 32'(r_over), 32'd1);
    chk("ovr spr_hit", 32'(r_hit), 32'h3F);
    chk("ovr reads", 32'(r_reads), 32'd96);
`ifdef OVERRUN_CNT_EN
    chk("ovr overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif

    // Reset asserted mid-FETCH clears outputs at once; nothing follows after release.
    spr_y = vecs[0].y; spr_base = vecs[0].base; next_line = vecs[0].line;
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst pre rom_en", 32'(rom_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst mid-fetch outputs", 32'({rom_en, rom_addr, buf_we, buf_sel, buf_addr, buf_wdata,
                                      spr_hit, busy, done, overrun}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int activity;
      activity = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        if (buf_we || rom_en || done || busy) activity++;
      end
      chk("rst no activity after release", 32'(activity), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
